mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback by issuing one-cycle write strobes.
- Drives the select lines for the immediate extender (ExtOp), ALU, next-PC unit, register-file destination and write-data mux.
- Takes Op/Funct from the instruction register and Zero from the ALU.

Parameters:
ILLEGAL_HALT, 0, 1 = an unsupported instruction enters HALT until reset; 0 = it is skipped and flagged.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU equality flag (rs==rt)
PCWr  out  1  PC write strobe
IRWr  out  1  IR write strobe
NPCOp  out  2  00 PC+4, 01 branch, 10 j/jal target (Imm28), 11 jr (rs)
RegWr  out  1  register-file write strobe
RegDst  out  2  00 rt, 01 rd, 10 $31
ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 shamt
ALUSrc  out  2  00 rt, 01 Imm32_lbit, 10 Imm32_hbit
ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLL
MemWr  out  1  data-memory write strobe
WDSel  out  2  00 ALU result, 01 memory data, 10 PC (already PC+4)
IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported encoding
State  out  3  current state, for debug

Behaviour:
- Supported instructions:
  - R-type (Op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - I/J-type: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is illegal.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=7.
- Reset: while rst_n=0 at a clock edge, the next state is FETCH. All strobes (PCWr, IRWr, RegWr, MemWr) and IllegalOp are forced to 0 combinationally while rst_n=0. Reset mid-instruction abandons it with no further strobes.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=10, then FETCH.
  - jal: PCWr=1, NPCOp=10, RegWr=1, RegDst=10, WDSel=10, then FETCH. The $31 write and the PC update happen on the same edge.
  - jr: PCWr=1, NPCOp=11, then FETCH.
  - Illegal: IllegalOp=1, then HALT if ILLEGAL_HALT=1, else FETCH.
  - All others: EXE.
- EXE:
  - beq: PCWr=Zero, NPCOp=01, then FETCH.
  - lw/sw: MEM.
  - All others: WB.
- MEM: sw asserts MemWr=1, then FETCH. lw goes to WB.
- WB: RegWr=1, then FETCH.
- HALT: all strobes 0; exits only through reset.
- Non-strobe selects are pure functions of Op/Funct, valid in every state. IR is stable after FETCH.

Select-line values per instruction:
- addiu/lw/sw: ExtOp=01, ALUSrc=01, ALUOp=ADD.
- ori: ExtOp=00, ALUSrc=01, ALUOp=OR.
- lui: ALUSrc=10, ALUOp=ADD (rs field is 0).
- beq: ExtOp=01, ALUSrc=00, ALUOp=SUB.
- sll: ExtOp=10, ALUSrc=01, ALUOp=SLL (datapath shifts rt by B[4:0]).
- Other R-type: ALUSrc=00, RegDst=01, ALUOp per Funct.
- RegDst is 00 for I-type; WDSel=01 only for lw.
- Unlisted selects default to 00.

Cycles per instruction:
- j/jal/jr: 2
- beq: 3
- R-type/I-type ALU ops: 4
- sw: 4
- lw: 5

Invariants:
- At most one of RegWr/MemWr is high in any cycle.
- IRWr is high only in FETCH.
- The state register never takes the unused encodings 5 or 6; if it does, the next state is FETCH.

Decomposition:
- Shared package mips_defs: opcode and funct constants, ALUOp/ExtOp/NPCOp/ALUSrc/RegDst/WDSel encodings, state encodings.
- One sub-module, mc_decode: purely combinational Op/Funct to instruction-class one-hots and the static selects.
- mc_ctrl holds the state register and the strobe logic.

Test Plan:
- Reset released, Op=addu: State sequence 0,1,2,4,0. IRWr/PCWr high in cycle 0, RegWr high in cycle 3 only, RegDst=01, ALUOp=000.
- lw, then sw: lw takes 5 cycles with WDSel=01 and RegWr in WB only. sw takes 4 cycles with MemWr in MEM only, RegWr never high, ExtOp=01.
- beq with Zero=1 gives PCWr=1 and NPCOp=01 in EXE. With Zero=0, PCWr=0 in EXE. Both return to FETCH after 3 cycles.
- jal: DECODE shows PCWr=1, RegWr=1, RegDst=10, WDSel=10, NPCOp=10, then FETCH. jr gives NPCOp=11 in 2 cycles.
- sll gives ExtOp=10, ALUOp=101. ori gives ExtOp=00. lui gives ALUSrc=10.
- Op=111111: IllegalOp pulses one cycle. With ILLEGAL_HALT=0 the next state is FETCH; with ILLEGAL_HALT=1, State=7 and all strobes stay 0 until rst_n=0 at an edge returns it to FETCH.
- rst_n driven low in MEM of sw: MemWr=0 that cycle, State=0 after the edge.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Holds opcode/funct constants, select-line encodings, the controller
// state encoding and the instruction-class bundle produced by mc_decode.
package mips_defs;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes, IR[5:0]
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;

   // ALU operation
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;

   // Immediate extender
   localparam logic [1:0] EXT_ZERO  = 2'b00;
   localparam logic [1:0] EXT_SIGN  = 2'b01;
   localparam logic [1:0] EXT_SHAMT = 2'b10;

   // Next-PC source
   localparam logic [1:0] NPC_PC4    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   // ALU B operand
   localparam logic [1:0] SRC_RT    = 2'b00;
   localparam logic [1:0] SRC_IMM_L = 2'b01;
   localparam logic [1:0] SRC_IMM_H = 2'b10;

   // Register-file destination
   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   // Register-file write data
   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   // Controller states; 5 and 6 are unused encodings
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   // Instruction classes that change the state sequence or the strobes.
   // Plain ALU ops need no flag: they take the default EXE -> WB path.
   typedef struct packed {
      logic jr;
      logic j;
      logic jal;
      logic beq;
      logic lw;
      logic sw;
      logic illegal;
   } instr_cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the controller (reads Op/Funct/Zero, drives strobes and selects).
// slave : the datapath (drives Op/Funct/Zero, consumes strobes and selects).
// Strobes (PCWr, IRWr, RegWr, MemWr) are single-cycle write enables: the
// datapath commits the write on the rising edge that ends the cycle in
// which the strobe is high. There is no back-pressure.
interface mc_ctrl_if;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       PCWr;
   logic       IRWr;
   logic [1:0] NPCOp;
   logic       RegWr;
   logic [1:0] RegDst;
   logic [1:0] ExtOp;
   logic [1:0] ALUSrc;
   logic [2:0] ALUOp;
   logic       MemWr;
   logic [1:0] WDSel;
   logic       IllegalOp;
   logic [2:0] State;

   modport master (
      input  Op, Funct, Zero,
      output PCWr, IRWr, NPCOp, RegWr, RegDst, ExtOp, ALUSrc, ALUOp,
             MemWr, WDSel, IllegalOp, State
   );

   modport slave (
      output Op, Funct, Zero,
      input  PCWr, IRWr, NPCOp, RegWr, RegDst, ExtOp, ALUSrc, ALUOp,
             MemWr, WDSel, IllegalOp, State
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder.
// Ports:
//   i_op, i_funct : IR opcode and function fields
//   o_cls         : instruction-class flags used by the sequencer
//   o_npc_op      : next-PC source for this instruction (used outside FETCH)
//   o_reg_dst, o_ext_op, o_alu_src, o_alu_op, o_wd_sel : static selects
module mc_decode
   import mips_defs::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output instr_cls_t o_cls,
   output logic [1:0] o_npc_op,
   output logic [1:0] o_reg_dst,
   output logic [1:0] o_ext_op,
   output logic [1:0] o_alu_src,
   output logic [2:0] o_alu_op,
   output logic [1:0] o_wd_sel
);

   always_comb begin
      o_cls     = '0;
      o_npc_op  = NPC_PC4;
      o_reg_dst = DST_RT;
      o_ext_op  = EXT_ZERO;
      o_alu_src = SRC_RT;
      o_alu_op  = ALU_ADD;
      o_wd_sel  = WD_ALU;
      case (i_op)
         OP_RTYPE: begin
            o_reg_dst = DST_RD;
            case (i_funct)
               FN_ADDU: o_alu_op = ALU_ADD;
               FN_SUBU: o_alu_op = ALU_SUB;
               FN_AND:  o_alu_op = ALU_AND;
               FN_OR:   o_alu_op = ALU_OR;
               FN_SLT:  o_alu_op = ALU_SLT;
               FN_SLL: begin
                  // shamt goes through the extender into ALU B
                  o_ext_op  = EXT_SHAMT;
                  o_alu_src = SRC_IMM_L;
                  o_alu_op  = ALU_SLL;
               end
               FN_JR: begin
                  o_cls.jr = 1'b1;
                  o_npc_op = NPC_JR;
               end
               default: begin
                  o_cls.illegal = 1'b1;
                  o_reg_dst     = DST_RT;
               end
            endcase
         end
         OP_ADDIU: begin
            o_ext_op  = EXT_SIGN;
            o_alu_src = SRC_IMM_L;
         end
         OP_ORI: begin
            o_alu_src = SRC_IMM_L;
            o_alu_op  = ALU_OR;
         end
         OP_LUI: begin
            // rs is $0, so ADD passes the upper-half immediate through
            o_alu_src = SRC_IMM_H;
         end
         OP_LW: begin
            o_cls.lw  = 1'b1;
            o_ext_op  = EXT_SIGN;
            o_alu_src = SRC_IMM_L;
            o_wd_sel  = WD_MEM;
         end
         OP_SW: begin
            o_cls.sw  = 1'b1;
            o_ext_op  = EXT_SIGN;
            o_alu_src = SRC_IMM_L;
         end
         OP_BEQ: begin
            o_cls.beq = 1'b1;
            o_npc_op  = NPC_BRANCH;
            o_ext_op  = EXT_SIGN;
            o_alu_op  = ALU_SUB;
         end
         OP_J: begin
            o_cls.j  = 1'b1;
            o_npc_op = NPC_JUMP;
         end
         OP_JAL: begin
            o_cls.jal = 1'b1;
            o_npc_op  = NPC_JUMP;
            o_reg_dst = DST_RA;
            o_wd_sel  = WD_PC;
         end
         default: o_cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: state register and write-strobe sequencing.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; also gates all strobes and
//           IllegalOp combinationally so an abandoned instruction writes nothing
//   bus   : mc_ctrl_if master (Op/Funct/Zero in; strobes, selects, State out)
// Parameter ILLEGAL_HALT: 1 = unsupported encoding parks in HALT until reset,
//                         0 = it is flagged and skipped.
module mc_ctrl
   import mips_defs::*;
#(
   parameter logic ILLEGAL_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   mc_ctrl_if.master  bus
);

   instr_cls_t w_cls;
   logic [1:0] w_npc_static;
   state_t     r_state;
   state_t     w_next_state;
   logic       w_pc_wr;
   logic       w_ir_wr;
   logic       w_reg_wr;
   logic       w_mem_wr;
   logic       w_illegal;
   logic [1:0] w_npc_op;

   mc_decode u_decode (
      .i_op      (bus.Op),
      .i_funct   (bus.Funct),
      .o_cls     (w_cls),
      .o_npc_op  (w_npc_static),
      .o_reg_dst (bus.RegDst),
      .o_ext_op  (bus.ExtOp),
      .o_alu_src (bus.ALUSrc),
      .o_alu_op  (bus.ALUOp),
      .o_wd_sel  (bus.WDSel)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = S_FETCH;
      w_pc_wr      = 1'b0;
      w_ir_wr      = 1'b0;
      w_reg_wr     = 1'b0;
      w_mem_wr     = 1'b0;
      w_illegal    = 1'b0;
      w_npc_op     = w_npc_static;
      case (r_state)
         S_FETCH: begin
            w_ir_wr      = 1'b1;
            w_pc_wr      = 1'b1;
            w_npc_op     = NPC_PC4;
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            if (w_cls.j || w_cls.jr) begin
               w_pc_wr = 1'b1;
            end else if (w_cls.jal) begin
               // $31 gets PC+4 on the same edge the PC takes the target
               w_pc_wr  = 1'b1;
               w_reg_wr = 1'b1;
            end else if (w_cls.illegal) begin
               w_illegal    = 1'b1;
               w_next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
            end else begin
               w_next_state = S_EXE;
            end
         end
         S_EXE: begin
            if (w_cls.beq) begin
               w_pc_wr = bus.Zero;
            end else if (w_cls.lw || w_cls.sw) begin
               w_next_state = S_MEM;
            end else begin
               w_next_state = S_WB;
            end
         end
         S_MEM: begin
            if (w_cls.sw) w_mem_wr = 1'b1;
            else          w_next_state = S_WB;
         end
         S_WB: begin
            w_reg_wr = 1'b1;
         end
         S_HALT: begin
            w_next_state = S_HALT;
         end
         default: begin
            // unused encodings recover to FETCH with no strobes
            w_next_state = S_FETCH;
         end
      endcase
   end

   assign bus.PCWr      = w_pc_wr   & rst_n;
   assign bus.IRWr      = w_ir_wr   & rst_n;
   assign bus.RegWr     = w_reg_wr  & rst_n;
   assign bus.MemWr     = w_mem_wr  & rst_n;
   assign bus.IllegalOp = w_illegal & rst_n;
   assign bus.NPCOp     = w_npc_op;
   assign bus.State     = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (skip / halt on illegal) share the
// instruction stream. A driver issues one cycle at a time and pushes the
// expected output vector; a negedge monitor pops and compares.
module tb_mc_ctrl;

  typedef enum int {
    K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_SLL, K_JR, K_ADDIU,
    K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
  } kind_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic [5:0] op, funct;
  logic       zero;

  mc_ctrl_if bus0 ();
  mc_ctrl_if bus1 ();

  assign bus0.Op = op;  assign bus0.Funct = funct;  assign bus0.Zero = zero;
  assign bus1.Op = op;  assign bus1.Funct = funct;  assign bus1.Zero = zero;

  mc_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
  mc_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

  // ---------------- reference model ----------------
  logic [11:0] ill_tab [6];
  initial begin
    ill_tab[0] = {6'b111111, 6'b000000};
    ill_tab[1] = {6'b000001, 6'b000000};
    ill_tab[2] = {6'b100000, 6'b100001};
    ill_tab[3] = {6'b000000, 6'b100000};
    ill_tab[4] = {6'b000000, 6'b000010};
    ill_tab[5] = {6'b000000, 6'b001001};
  end

  task automatic encode(input kind_t k);
    logic [11:0] e;
    case (k)
      K_ADDU:  e = {6'b000000, 6'b100001};
      K_SUBU:  e = {6'b000000, 6'b100011};
      K_AND:   e = {6'b000000, 6'b100100};
      K_OR:    e = {6'b000000, 6'b100101};
      K_SLT:   e = {6'b000000, 6'b101010};
      K_SLL:   e = {6'b000000, 6'b000000};
      K_JR:    e = {6'b000000, 6'b001000};
      K_ADDIU: e = {6'b001001, 6'($urandom)};
      K_ORI:   e = {6'b001101, 6'($urandom)};
      K_LUI:   e = {6'b001111, 6'($urandom)};
      K_LW:    e = {6'b100011, 6'($urandom)};
      K_SW:    e = {6'b101011, 6'($urandom)};
      K_BEQ:   e = {6'b000100, 6'($urandom)};
      K_J:     e = {6'b000010, 6'($urandom)};
      K_JAL:   e = {6'b000011, 6'($urandom)};
      default: e = ill_tab[$urandom_range(0, 5)];
    endcase
    op    = e[11:6];
    funct = e[5:0];
  endtask

  // {npc(2), regdst(2), extop(2), alusrc(2), aluop(3), wdsel(2)}
  function automatic logic [12:0] sel_of(kind_t k);
    case (k)
      K_ADDU:  return {2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
      K_SUBU:  return {2'b00, 2'b01, 2'b00, 2'b00, 3'b001, 2'b00};
      K_AND:   return {2'b00, 2'b01, 2'b00, 2'b00, 3'b010, 2'b00};
      K_OR:    return {2'b00, 2'b01, 2'b00, 2'b00, 3'b011, 2'b00};
      K_SLT:   return {2'b00, 2'b01, 2'b00, 2'b00, 3'b100, 2'b00};
      K_SLL:   return {2'b00, 2'b01, 2'b10, 2'b01, 3'b101, 2'b00};
      K_JR:    return {2'b11, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
      K_ADDIU: return {2'b00, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
      K_SW:    return {2'b00, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
      K_LW:    return {2'b00, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01};
      K_ORI:   return {2'b00, 2'b00, 2'b00, 2'b01, 3'b011, 2'b00};
      K_LUI:   return {2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00};
      K_BEQ:   return {2'b01, 2'b00, 2'b01, 2'b00, 3'b001, 2'b00};
      K_J:     return {2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
      K_JAL:   return {2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10};
      default: return 13'd0;
    endcase
  endfunction

  // Cycles per instruction (illegal counts its FETCH+DECODE)
  function automatic int n_cycles(kind_t k);
    case (k)
      K_J, K_JAL, K_JR, K_ILL: return 2;
      K_BEQ:                   return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  // Phase (state number) of step s of an instruction
  function automatic int phase_of(kind_t k, int s);
    if (s < 3) return s;
    if (s == 3) return (k == K_LW || k == K_SW) ? 3 : 4;
    return 4;
  endfunction

  // {State, PCWr, IRWr, NPCOp, RegWr, RegDst, ExtOp, ALUSrc, ALUOp, MemWr, WDSel, IllegalOp}
  function automatic logic [20:0] exp_vec(kind_t k, int ph, logic z, logic rn);
    logic [12:0] s;
    logic [2:0]  st;
    logic        pc, ir, rw, mw, il;
    logic [1:0]  npc;
    s  = sel_of(k);
    st = ph[2:0];
    pc = 1'b0; ir = 1'b0; rw = 1'b0; mw = 1'b0; il = 1'b0;
    case (ph)
      0: begin ir = 1'b1; pc = 1'b1; end
      1: begin
        if (k == K_J || k == K_JR) pc = 1'b1;
        if (k == K_JAL) begin pc = 1'b1; rw = 1'b1; end
        if (k == K_ILL) il = 1'b1;
      end
      2: if (k == K_BEQ) pc = z;
      3: if (k == K_SW) mw = 1'b1;
      4: rw = 1'b1;
      default: ;
    endcase
    npc = (ph == 0) ? 2'b00 : s[12:11];
    return {st, pc & rn, ir & rn, npc, rw & rn, s[10:9], s[8:7], s[6:5], s[4:2],
            mw & rn, s[1:0], il & rn};
  endfunction

  // ---------------- scoreboard ----------------
  logic [20:0] exp0_q[$];
  logic [20:0] exp1_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  wire [20:0] obs0 = {bus0.State, bus0.PCWr, bus0.IRWr, bus0.NPCOp, bus0.RegWr, bus0.RegDst,
                      bus0.ExtOp, bus0.ALUSrc, bus0.ALUOp, bus0.MemWr, bus0.WDSel, bus0.IllegalOp};
  wire [20:0] obs1 = {bus1.State, bus1.PCWr, bus1.IRWr, bus1.NPCOp, bus1.RegWr, bus1.RegDst,
                      bus1.ExtOp, bus1.ALUSrc, bus1.ALUOp, bus1.MemWr, bus1.WDSel, bus1.IllegalOp};

  always @(negedge clk) begin
    logic [20:0] e;
    cyc++;
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      n_checks++;
      if (obs0 !== e) begin
        n_errors++;
        $display("FAIL dut0_vec cyc %0d op %b fn %b: got %h expected %h", cyc, op, funct, obs0, e);
      end
      n_checks++;
      if (bus0.RegWr && bus0.MemWr) begin
        n_errors++;
        $display("FAIL dut0_regwr_memwr cyc %0d: got both high, expected at most one", cyc);
      end
    end
    if (exp1_q.size() > 0) begin
      e = exp1_q.pop_front();
      n_checks++;
      if (obs1 !== e) begin
        n_errors++;
        $display("FAIL dut1_vec cyc %0d op %b fn %b: got %h expected %h", cyc, op, funct, obs1, e);
      end
      n_checks++;
      if (bus1.IRWr && bus1.State != 3'd0) begin
        n_errors++;
        $display("FAIL dut1_irwr cyc %0d: got IRWr=1 in state %0d, expected only in 0", cyc, bus1.State);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [20:0] e0, input logic [20:0] e1);
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    step();
  endtask

  // zmode < 0: random Zero; abort_at >= 0: rst_n low at that step
  task automatic run_instr(input kind_t k, input int abort_at, input int zmode);
    int   n, ph, hc;
    logic z;
    encode(k);
    n = n_cycles(k);
    for (int s = 0; s < n; s++) begin
      z    = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zero = z;
      ph   = phase_of(k, s);
      if (s == abort_at) begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        issue(exp_vec(k, ph, z, 1'b0), exp_vec(k, ph, z, 1'b0));
        rst0_n = 1'b1; rst1_n = 1'b1;
        return;
      end
      issue(exp_vec(k, ph, z, 1'b1), exp_vec(k, ph, z, 1'b1));
    end
    if (k == K_ILL) begin
      // dut0 already back in FETCH: hold it in reset while dut1 sits in HALT
      hc = $urandom_range(1, 3);
      for (int i = 0; i < hc; i++) begin
        zero   = 1'($urandom_range(0, 1));
        rst0_n = 1'b0;
        issue(exp_vec(k, 0, zero, 1'b0), exp_vec(k, 7, zero, 1'b1));
      end
      rst1_n = 1'b0;
      issue(exp_vec(k, 0, zero, 1'b0), exp_vec(k, 7, zero, 1'b0));
      rst0_n = 1'b1; rst1_n = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    kind_t k;
    int    ab;
    rst0_n = 1'b0; rst1_n = 1'b0;
    encode(K_ADDU);
    zero = 1'b0;
    step(); step();
    issue(exp_vec(K_ADDU, 0, 1'b0, 1'b0), exp_vec(K_ADDU, 0, 1'b0, 1'b0));
    rst0_n = 1'b1; rst1_n = 1'b1;

    run_instr(K_ADDU, -1, -1);
    run_instr(K_LW,   -1, -1);
    run_instr(K_SW,   -1, -1);
    run_instr(K_BEQ,  -1, 1);
    run_instr(K_BEQ,  -1, 0);
    run_instr(K_JAL,  -1, -1);
    run_instr(K_JR,   -1, -1);
    run_instr(K_SLL,  -1, -1);
    run_instr(K_ORI,  -1, -1);
    run_instr(K_LUI,  -1, -1);
    run_instr(K_ILL,  -1, -1);
    run_instr(K_J,    -1, -1);
    run_instr(K_SW,    3, -1);
    run_instr(K_SUBU, -1, -1);

    for (int i = 0; i < 300; i++) begin
      k  = kind_t'($urandom_range(0, 15));
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n_cycles(k) - 1) : -1;
      run_instr(k, ab, -1);
    end

    for (int i = 0; i < 5 && (exp0_q.size() > 0 || exp1_q.size() > 0); i++) step();
    n_checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp0_q.size(), exp1_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
